// File: rtl/uart_defs_pkg.sv
// uart_defs: shared UART state encoding, frame defaults and counter sizing helper
package uart_defs;
    localparam int DBIT_DEF       = 8;
    localparam int OVERSAMPLE_DEF = 16;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uart_state_t;
    function automatic int cw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running oversample tick, one clock high every TICK_DIV clocks
module baud_tick_gen
    import uart_defs::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);
    localparam int W = cw(TICK_DIV);
    logic [W-1:0] cnt;
    assign o_tick = cnt == W'(TICK_DIV - 1);
    always_ff @(posedge i_clk)
        cnt <= (i_reset || o_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled UART receiver with glitch rejection, framing error and break handling
module uart_receiver
    import uart_defs::*;
#(
    parameter int DBIT       = DBIT_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int TICK_DIV   = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    output logic [DBIT-1:0] o_rx_data,
    output logic            o_rx_done,
    output logic            o_frame_error,
    output logic            o_rx_busy
);
    localparam int SW = cw(OVERSAMPLE);
    localparam int NW = cw(DBIT);
    uart_state_t     state, state_n;
    logic [1:0]      sync;
    logic            rx, tick, done_n, ferr_n;
    logic [SW-1:0]   s, s_n;
    logic [NW-1:0]   n, n_n;
    logic [DBIT-1:0] b, b_n, data_n;
    assign rx        = sync[1];
    assign o_rx_busy = state != IDLE;
    baud_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .o_tick (tick)
    );
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync          <= 2'b11;
            state         <= IDLE;
            s             <= '0;
            n             <= '0;
            b             <= '0;
            o_rx_data     <= '0;
            o_rx_done     <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            sync          <= {sync[0], i_rx};
            state         <= state_n;
            s             <= s_n;
            n             <= n_n;
            b             <= b_n;
            o_rx_data     <= data_n;
            o_rx_done     <= done_n;
            o_frame_error <= ferr_n;
        end
    end
    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        data_n  = o_rx_data;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE:      if (!rx) state_n = START;
            START:     if (tick) begin
                           if (s == SW'(OVERSAMPLE / 2 - 1)) state_n = rx ? IDLE : DATA;
                           else s_n = s + 1'b1;
                       end
            DATA:      if (tick) begin
                           if (s == SW'(OVERSAMPLE - 1)) begin
                               s_n = '0;
                               b_n = DBIT'({rx, b} >> 1);
                               if (n == NW'(DBIT - 1)) state_n = STOP;
                               else n_n = n + 1'b1;
                           end else s_n = s + 1'b1;
                       end
            STOP:      if (tick) begin
                           if (s == SW'(OVERSAMPLE - 1)) begin
                               state_n = rx ? IDLE : WAIT_HIGH;
                               data_n  = rx ? b : o_rx_data;
                               done_n  = rx;
                               ferr_n  = !rx;
                           end else s_n = s + 1'b1;
                       end
            WAIT_HIGH: if (rx) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
        // every state entry starts with fresh tick and bit counts
        if (state_n != state) begin
            s_n = '0;
            n_n = '0;
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: random and directed frames checked against an expected-event queue model
module tb_uart_receiver;
    typedef struct {
        bit         err;
        logic [7:0] d;
        longint     t;
    } ev_t;
    logic       clk = 1'b0, i_reset = 1'b1, rx0 = 1'b1, rx1 = 1'b1;
    logic [7:0] data0, data1;
    logic       done0, done1, ferr0, ferr1, busy0, busy1;
    int         checks = 0, errors = 0;
    longint     cyc = 0;
    bit         rst_q;
    ev_t        q0[$], q1[$];
    logic [7:0] last[2];
    int         ndone[2], nerr[2];
    bit         prev[2];
    uart_receiver #(.TICK_DIV(1)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_rx(rx0),
        .o_rx_data(data0), .o_rx_done(done0), .o_frame_error(ferr0), .o_rx_busy(busy0)
    );
    uart_receiver #(.TICK_DIV(4)) dut4 (
        .i_clk(clk), .i_reset(i_reset), .i_rx(rx1),
        .o_rx_data(data1), .o_rx_done(done1), .o_frame_error(ferr1), .o_rx_busy(busy1)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= i_reset;
    end
    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask
    task automatic mon(input int w, input logic done, input logic ferr, input logic [7:0] data, input int tdiv);
        ev_t    e;
        longint dt;
        if (rst_q) begin
            last[w] = 8'h00;
            if (w == 0) q0.delete(); else q1.delete();
        end
        check($sformatf("exclusive_pulses[%0d]", w), done & ferr, 0);
        check($sformatf("no_consecutive_pulse[%0d]", w), prev[w] & (done | ferr), 0);
        prev[w] = done | ferr;
        if (done | ferr) begin
            if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0))
                check($sformatf("unexpected_pulse[%0d]", w), 1, 0);
            else begin
                if (w == 0) e = q0.pop_front(); else e = q1.pop_front();
                dt = cyc - e.t;
                check($sformatf("pulse_is_frame_error[%0d]", w), ferr, e.err);
                check($sformatf("pulse_time_ok[%0d] dt=%0d", w, dt), (dt >= 151 * tdiv + 1 && dt <= 152 * tdiv + 4), 1);
                if (done) begin
                    ndone[w]++;
                    last[w] = e.d;
                end else nerr[w]++;
            end
        end
        check($sformatf("rx_data[%0d]", w), data, last[w]);
    endtask
    always @(negedge clk) begin
        mon(0, done0, ferr0, data0, 1);
        mon(1, done1, ferr1, data1, 4);
    end
    task automatic drive(input int w, input logic v, input int n);
        if (w == 0) rx0 = v; else rx1 = v;
        repeat (n) @(negedge clk);
    endtask
    task automatic send(input int w, input logic [7:0] d, input bit ok, input int extra, input int gap);
        int  bc = (w == 0) ? 16 : 64;
        ev_t e;
        e.err = !ok;
        e.d   = d;
        e.t   = cyc;
        if (w == 0) q0.push_back(e); else q1.push_back(e);
        drive(w, 1'b0, bc);
        for (int i = 0; i < 8; i++) drive(w, d[i], bc);
        drive(w, ok, bc + (ok ? 0 : extra));
        if (gap > 0) drive(w, 1'b1, gap);
    endtask
    initial begin
        logic [7:0] d;
        last  = '{8'h00, 8'h00};
        ndone = '{0, 0};
        nerr  = '{0, 0};
        prev  = '{1'b0, 1'b0};
        repeat (3) @(negedge clk);
        check("reset_data0", data0, 0);
        check("reset_busy0", busy0, 0);
        check("reset_done0", done0, 0);
        check("reset_ferr0", ferr0, 0);
        check("reset_data1", data1, 0);
        check("reset_busy1", busy1, 0);
        i_reset = 1'b0;
        drive(0, 1'b1, 20);
        send(0, 8'h02, 1'b1, 0, 32);
        check("single_frame_data", data0, 8'h02);
        check("single_frame_done_count", ndone[0], 1);
        check("single_frame_no_error", nerr[0], 0);
        send(0, 8'h24, 1'b1, 0, 0);
        send(0, 8'hA5, 1'b1, 0, 16);
        check("back_to_back_data", data0, 8'hA5);
        check("back_to_back_done_count", ndone[0], 3);
        send(0, 8'h55, 1'b0, 48, 0);
        check("break_busy_held", busy0, 1);
        check("break_error_count", nerr[0], 1);
        check("break_keeps_data", data0, 8'hA5);
        check("break_no_done", ndone[0], 3);
        drive(0, 1'b1, 32);
        check("break_busy_released", busy0, 0);
        drive(0, 1'b0, 4);
        drive(0, 1'b1, 12);
        check("glitch_busy_low", busy0, 0);
        drive(0, 1'b1, 20);
        check("glitch_no_done", ndone[0], 3);
        check("glitch_no_error", nerr[0], 1);
        drive(0, 1'b0, 16);
        drive(0, 1'b1, 72);
        i_reset = 1'b1;
        @(negedge clk);
        check("midframe_reset_data", data0, 0);
        check("midframe_reset_busy", busy0, 0);
        check("midframe_reset_done", done0, 0);
        check("midframe_reset_ferr", ferr0, 0);
        i_reset = 1'b0;
        drive(0, 1'b1, 32);
        send(0, 8'h11, 1'b1, 0, 16);
        check("after_reset_data", data0, 8'h11);
        send(1, 8'hC3, 1'b1, 0, 64);
        check("div4_data", data1, 8'hC3);
        check("div4_done_count", ndone[1], 1);
        repeat (40) begin
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) != 0) send(0, d, 1'b1, 0, $urandom_range(0, 40));
            else begin
                send(0, d, 1'b0, $urandom_range(0, 40), 0);
                drive(0, 1'b1, $urandom_range(16, 40));
            end
        end
        repeat (4) send(1, 8'($urandom_range(0, 255)), 1'b1, 0, $urandom_range(0, 100));
        drive(0, 1'b1, 50);
        check("missing_pulses0", q0.size(), 0);
        check("missing_pulses1", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
